lcd_string_writer: RTL and testbench

// - Sits directly downstream of the game's 16-character display formatter.
// - Takes its 128-bit ASCII line and drives a 16x1/16x2 HD44780-compatible LCD over an 8-bit parallel bus.
// - Runs power-up init once, then rewrites line 1 whenever the input string changes.
// - The formatter stays purely combinational; all LCD bus timing lives here.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_byte_tx.sv | 69 ++++++
 rtl/lcd_string_writer.sv | 122 ++++++++++++
 tb/tb_lcd_string_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command codes, writer/transmitter state types and init ROM
package lcd_pkg;
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;
    localparam logic [7:0] LCD_BLANK    = 8'h20;

    typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, ADDR, CHARS} lcd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_WAIT} tx_phase_t;

    function automatic logic [7:0] init_byte(input logic [2:0] step);
        return step <= 3'd1 ? LCD_FUNC_SET :
               step == 3'd2 ? LCD_DISP_ON  :
               step == 3'd3 ? LCD_CLEAR    : LCD_ENTRY;
    endfunction
endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: one LCD bus write (setup cycle, E pulse, post-byte wait)
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000,
    parameter int CW             = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_val,
    input  logic       rs,
    input  logic       is_clear,
    output logic       busy,
    output logic       done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_e
);
    localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT_CYC - 1);

    tx_phase_t     phase;
    logic [CW-1:0] cnt;
    logic          clr;

    assign busy = phase != TX_IDLE;
    // done marks the last wait cycle so the next byte's setup follows with no gap
    assign done = phase == TX_WAIT && cnt == (clr ? CLEAR_LAST : CMD_LAST);

    // byte sequencer: accept, setup, E high, then hold bus through the wait
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= TX_IDLE;
            cnt      <= '0;
            clr      <= 1'b0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
        end else if (start && (!busy || done)) begin
            phase    <= TX_SETUP;
            cnt      <= '0;
            clr      <= is_clear;
            lcd_data <= byte_val;
            lcd_rs   <= rs;
            lcd_e    <= 1'b0;
        end else begin
            case (phase)
                TX_SETUP: begin
                    phase <= TX_PULSE;
                    lcd_e <= 1'b1;
                end
                TX_PULSE: begin
                    cnt   <= cnt == E_LAST ? '0 : cnt + 1'b1;
                    phase <= cnt == E_LAST ? TX_WAIT : TX_PULSE;
                    lcd_e <= cnt != E_LAST;
                end
                TX_WAIT: begin
                    cnt   <= cnt + 1'b1;
                    phase <= done ? TX_IDLE : TX_WAIT;
                end
                default: phase <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/lcd_string_writer.sv
// lcd_string_writer: HD44780 init, then rewrites line 1 whenever the input string changes
module lcd_string_writer
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT_CYC  = 750000,
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] str,
    output logic [7:0]   lcd_data,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic         ready,
    output logic         frame_done
);
    localparam int CW = $clog2((INIT_WAIT_CYC > CLEAR_WAIT_CYC ? INIT_WAIT_CYC : CLEAR_WAIT_CYC) + 1);
    localparam logic [CW-1:0] P_LAST = CW'(INIT_WAIT_CYC - 1);

    lcd_state_t    state;
    logic [CW-1:0] pcnt;
    logic [2:0]    step;
    logic [3:0]    col;
    logic          last;
    logic          dirty;
    logic [127:0]  snapshot;
    logic          busy;
    logic          done;
    logic          start;
    logic [7:0]    tx_byte;
    logic          tx_rs;

    assign lcd_rw = 1'b0;

    // next byte to send; last holds off issuing while the final byte of a sequence drains
    always_comb begin
        tx_byte = state == INIT ? init_byte(step) : state == ADDR ? LCD_LINE1 : snapshot[{~col, 3'b000} +: 8];
        tx_rs   = state == CHARS;
        start   = (state == INIT || state == ADDR || state == CHARS) && !last && (!busy || done);
    end

    lcd_byte_tx #(
        .E_PULSE_CYC   (E_PULSE_CYC),
        .CMD_WAIT_CYC  (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC),
        .CW            (CW)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .byte_val(tx_byte),
        .rs      (tx_rs),
        .is_clear(!tx_rs && tx_byte == LCD_CLEAR),
        .busy    (busy),
        .done    (done),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_e   (lcd_e)
    );

    // top-level sequencing: power wait, init bytes, then one frame per string change
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PWR_WAIT;
            pcnt       <= '0;
            step       <= '0;
            col        <= '0;
            last       <= 1'b0;
            dirty      <= 1'b1;
            snapshot   <= {16{LCD_BLANK}};
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    pcnt  <= pcnt + 1'b1;
                    state <= pcnt == P_LAST ? INIT : PWR_WAIT;
                end
                INIT: begin
                    if (start) begin
                        step <= step + 3'd1;
                        last <= step == 3'd4;
                    end else if (last && done) begin
                        last  <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (dirty || str != snapshot) begin
                        snapshot <= str;
                        dirty    <= 1'b0;
                        ready    <= 1'b0;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (start) begin
                        col   <= '0;
                        state <= CHARS;
                    end
                end
                CHARS: begin
                    if (start) begin
                        col  <= col + 4'd1;
                        last <= col == 4'd15;
                    end else if (last && done) begin
                        last       <= 1'b0;
                        ready      <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_string_writer.sv
// tb_lcd_string_writer: scoreboard bench for the LCD line writer
module tb_lcd_string_writer;
    localparam int INIT_W = 20;
    localparam int E_P    = 2;
    localparam int CMD_W  = 5;
    localparam int CLR_W  = 10;

    logic         clk = 0;
    logic         rst_n;
    logic [127:0] str;
    logic [7:0]   lcd_data;
    logic         lcd_rs, lcd_rw, lcd_e, ready, frame_done;

    lcd_string_writer #(
        .INIT_WAIT_CYC (INIT_W),
        .E_PULSE_CYC   (E_P),
        .CMD_WAIT_CYC  (CMD_W),
        .CLEAR_WAIT_CYC(CLR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .str       (str),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .ready     (ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] bus;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   rises = 0, frames = 0, cyc = 0, fd_cyc = 0, rise_cyc = 0;
    int   hi = 0, lo = -1;
    logic prev_e = 0;
    logic [8:0] prev_bus = '0;

    localparam logic [127:0] BLANK = "                ";
    localparam logic [127:0] WIN   = "      WIN       ";
    localparam logic [127:0] TIE   = "      TIE       ";
    localparam logic [127:0] LOSE  = "      LOSE      ";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // gap = low cycles between the previous byte's E fall and this byte's E rise (-1: not checked)
    task automatic push(input logic rs, input logic [7:0] b, input int gap);
        exp_t e;
        e.bus = {rs, b};
        e.gap = gap;
        q.push_back(e);
    endtask

    // back-to-back bytes: wait cycles plus one setup cycle; after clear the wait is CLR_W
    task automatic push_init();
        push(0, 8'h38, -1);
        push(0, 8'h38, CMD_W + 1);
        push(0, 8'h0C, CMD_W + 1);
        push(0, 8'h01, CMD_W + 1);
        push(0, 8'h06, CLR_W + 1);
    endtask

    task automatic push_frame(input logic [127:0] s);
        push(0, 8'h80, -1);
        for (int i = 0; i < 16; i++) push(1, s[127 - 8*i -: 8], CMD_W + 1);
    endtask

    task automatic wait_rises(input string name, input int target);
        int n = 0;
        while (rises < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(name, rises >= target, 1);
    endtask

    task automatic wait_frames(input string name, input int target);
        int n = 0;
        while (frames < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, frames >= target, 1);
    endtask

    always @(posedge clk) cyc++;

    // monitor: pops the scoreboard at each E rise, plus always-on bus protocol checks
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 0;
            hi = 0;
            lo = -1;
        end else begin
            if (lcd_rw) chk("rw_low", lcd_rw, 0);
            if (lcd_e && !prev_e) begin
                rises++;
                rise_cyc = cyc;
                if (q.size() == 0) chk("unexpected_byte", {lcd_rs, lcd_data}, 9'h1FF);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("byte", {lcd_rs, lcd_data}, e.bus);
                    if (e.gap >= 0) chk("gap_before_byte", lo, e.gap);
                end
                hi = 1;
            end else if (lcd_e) begin
                chk("bus_stable_e_high", {lcd_rs, lcd_data}, prev_bus);
                hi++;
            end else if (prev_e) begin
                chk("e_pulse_width", hi, E_P);
                lo = 1;
            end else if (lo >= 0) lo++;
            if (frame_done) begin
                frames++;
                fd_cyc = cyc;
            end
            prev_e = lcd_e;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    initial begin
        int r0, f0;
        rst_n = 0;
        str = BLANK;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", lcd_data, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_ready", ready, 0);
        chk("rst_frame_done", frame_done, 0);
        push_init();
        push_frame(BLANK);
        rst_n = 1;
        // INIT_W cycles of a fully quiet bus after release
        for (int i = 0; i < INIT_W; i++) begin
            @(posedge clk);
            #1;
            chk("pwr_wait_quiet", {lcd_e, lcd_rs, lcd_data, ready}, 0);
        end
        wait_frames("first_frame", 1);
        chk("ready_after_frame", ready, 1);
        chk("queue_after_first", q.size(), 0);

        r0 = rises;
        f0 = frames;
        repeat (500) @(posedge clk);
        #1;
        chk("hold_no_bytes", rises, r0);
        chk("hold_no_frames", frames, f0);
        chk("hold_ready", ready, 1);

        // WIN frame; two changes mid-frame collapse into one LOSE frame
        str = WIN;
        push_frame(WIN);
        push_frame(LOSE);
        r0 = rises;
        f0 = frames;
        wait_rises("reach_col7", r0 + 9);
        #1 str = TIE;
        wait_rises("reach_col10", r0 + 12);
        #1 str = LOSE;
        wait_frames("win_frame_done", f0 + 1);
        wait_rises("second_frame_start", rises + 1);
        // frame_done cycle, then ADDR, then setup; E rises on the third cycle after frame_done
        chk("refresh_latency", rise_cyc - fd_cyc, 3);
        wait_frames("lose_frame_done", f0 + 2);
        repeat (100) @(posedge clk);
        #1;
        chk("one_followup_frame", frames, f0 + 2);
        chk("queue_after_lose", q.size(), 0);

        // reset while E is high mid-frame
        str = WIN;
        push_frame(WIN);
        wait_rises("mid_frame", rises + 6);
        for (int i = 0; i < 50 && !lcd_e; i++) @(negedge clk);
        #2 rst_n = 0;
        @(posedge clk);
        #1;
        chk("rst_drops_e", lcd_e, 0);
        chk("rst_clears_data", lcd_data, 0);
        q.delete();
        push_init();
        push_frame(WIN);
        @(posedge clk);
        #1 rst_n = 1;
        f0 = frames;
        wait_frames("reinit_frame", f0 + 1);
        repeat (20) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        chk("final_ready", ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
